// File: rtl/nmea_pkg.sv
// Shared constants, parse-state enum and small decode helpers for the NMEA RMC time loader.
package nmea_pkg;

  localparam logic [7:0]  ASCII_DOLLAR = 8'h24;
  localparam logic [7:0]  ASCII_COMMA  = 8'h2C;
  localparam logic [7:0]  ASCII_STAR   = 8'h2A;
  localparam logic [7:0]  ASCII_DOT    = 8'h2E;
  localparam logic [7:0]  ASCII_A      = 8'h41;
  localparam logic [23:0] ASCII_RMC    = 24'h524D43;

  localparam logic [5:0]  MAX_SEC  = 6'd59;
  localparam logic [5:0]  MAX_MIN  = 6'd59;
  localparam logic [5:0]  MAX_HOUR = 6'd23;

  localparam int unsigned ADDR_LEN = 5;
  localparam int unsigned TIME_LEN = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_TIME,
    ST_FRAC,
    ST_STATUS,
    ST_SKIP,
    ST_CK_HI,
    ST_CK_LO
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if ((c >= 8'h30) && (c <= 8'h39)) return {1'b1, c[3:0]};
    if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66)))
      return {1'b1, 4'(c[3:0] + 4'd9)};
    return 5'd0;
  endfunction

  // Expected sentence-id character at address positions 2..4.
  function automatic logic [7:0] rmc_char(input logic [2:0] idx);
    case (idx)
      3'd2:    return ASCII_RMC[23:16];
      3'd3:    return ASCII_RMC[15:8];
      default: return ASCII_RMC[7:0];
    endcase
  endfunction

  function automatic logic [5:0] bcd_to_bin(input logic [7:0] bcd);
    logic [6:0] t;
    t = 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    return 6'(t);
  endfunction

endpackage

// File: rtl/rtc_time_inc.sv
// Combinational time + 1 s with local hour offset; wraps 60/60/24.
module rtc_time_inc
  import nmea_pkg::*;
#(
  parameter int unsigned HOUR_OFFSET = 0
) (
  input  logic [5:0] hh_in,
  input  logic [5:0] mm_in,
  input  logic [5:0] ss_in,
  output logic [5:0] hh_out,
  output logic [5:0] mm_out,
  output logic [5:0] ss_out
);

  localparam logic [6:0] OFFSET_MOD = 7'(HOUR_OFFSET % 24);

  logic       sec_wrap;
  logic       min_wrap;
  logic [6:0] hour_sum;

  // Input hour is at most 23, so one conditional subtract covers the mod-24 wrap.
  always_comb begin
    sec_wrap = (ss_in >= MAX_SEC);
    min_wrap = sec_wrap && (mm_in >= MAX_MIN);
    ss_out   = sec_wrap ? 6'd0 : 6'(ss_in + 6'd1);
    mm_out   = mm_in;
    if (sec_wrap) mm_out = min_wrap ? 6'd0 : 6'(mm_in + 6'd1);
    hour_sum = 7'(hh_in) + 7'(min_wrap) + OFFSET_MOD;
    hh_out   = (hour_sum > 7'(MAX_HOUR)) ? 6'(hour_sum - 7'd24) : 6'(hour_sum);
  end

endmodule

// File: rtl/nmea_time_loader.sv
// Parses NMEA RMC sentences and loads time+1 s into the RTC one cycle after PPS.
// Optional checksum verification is enabled with `define NMEA_CHECKSUM_EN.
module nmea_time_loader
  import nmea_pkg::*;
#(
  parameter int unsigned HOUR_OFFSET = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       pps,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [5:0] hour_out,
  output logic       write_data,
  output logic       time_pending,
  output logic       sentence_ok,
  output logic [7:0] err_count
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [23:0] bcd_q, bcd_d;
`ifdef NMEA_CHECKSUM_EN
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  ck_hi_q, ck_hi_d;
  logic [4:0]  hex_c;
`endif

  logic        accept_c;
  logic        reject_c;
  logic        range_ok_c;

  logic [5:0]  ld_sec_q, ld_sec_d, ld_min_q, ld_min_d, ld_hour_q, ld_hour_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic        write_q, write_d;
  logic        pending_q, pending_d;
  logic        ok_q, ok_d;
  logic [7:0]  err_q, err_d;

  logic [5:0]  inc_hh, inc_mm, inc_ss;

  // Range check on raw BCD digits; each digit is already known to be 0..9.
  assign range_ok_c = ((bcd_q[23:20] < 4'd2) || ((bcd_q[23:20] == 4'd2) && (bcd_q[19:16] < 4'd4)))
                   && (bcd_q[15:12] < 4'd6)
                   && (bcd_q[7:4]   < 4'd6);

  rtc_time_inc #(
    .HOUR_OFFSET (HOUR_OFFSET)
  ) u_inc (
    .hh_in  (bcd_to_bin(bcd_q[23:16])),
    .mm_in  (bcd_to_bin(bcd_q[15:8])),
    .ss_in  (bcd_to_bin(bcd_q[7:0])),
    .hh_out (inc_hh),
    .mm_out (inc_mm),
    .ss_out (inc_ss)
  );

  // Sentence parser: advances only on rx_valid; '$' restarts from any state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    accept_c = 1'b0;
    reject_c = 1'b0;
`ifdef NMEA_CHECKSUM_EN
    acc_d    = acc_q;
    ck_hi_d  = ck_hi_q;
    hex_c    = hex_decode(rx_data);
    if (rx_valid && (state_q inside {ST_ADDR, ST_TIME, ST_FRAC, ST_STATUS, ST_SKIP})
        && (rx_data != ASCII_STAR))
      acc_d = acc_q ^ rx_data;
`endif
    if (rx_valid) begin
      if (rx_data == ASCII_DOLLAR) begin
        state_d = ST_ADDR;
        cnt_d   = 3'd0;
        bcd_d   = 24'd0;
`ifdef NMEA_CHECKSUM_EN
        acc_d   = 8'd0;
        ck_hi_d = 4'd0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (cnt_q == 3'(ADDR_LEN)) begin
              state_d = (rx_data == ASCII_COMMA) ? ST_TIME : ST_IDLE;
              cnt_d   = 3'd0;
            end else if ((cnt_q >= 3'd2) && (rx_data != rmc_char(cnt_q))) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          ST_TIME: begin
            if (is_digit(rx_data)) begin
              bcd_d = {bcd_q[19:0], rx_data[3:0]};
              if (cnt_q == 3'(TIME_LEN - 1)) begin
                state_d = ST_FRAC;
                cnt_d   = 3'd0;
              end else begin
                cnt_d = cnt_q + 3'd1;
              end
            end else begin
              reject_c = 1'b1;
            end
          end
          ST_FRAC: begin
            if (rx_data == ASCII_COMMA) state_d = ST_STATUS;
            else if (!(is_digit(rx_data) || (rx_data == ASCII_DOT))) reject_c = 1'b1;
          end
          ST_STATUS: begin
            if (rx_data == ASCII_A) state_d = ST_SKIP;
            else reject_c = 1'b1;
          end
          ST_SKIP: begin
            if (rx_data == ASCII_STAR) begin
`ifdef NMEA_CHECKSUM_EN
              state_d = ST_CK_HI;
`else
              if (range_ok_c) accept_c = 1'b1;
              else reject_c = 1'b1;
`endif
            end
          end
`ifdef NMEA_CHECKSUM_EN
          ST_CK_HI: begin
            if (hex_c[4]) begin
              ck_hi_d = hex_c[3:0];
              state_d = ST_CK_LO;
            end else begin
              reject_c = 1'b1;
            end
          end
          ST_CK_LO: begin
            if (hex_c[4] && ({ck_hi_q, hex_c[3:0]} == acc_q) && range_ok_c) accept_c = 1'b1;
            else reject_c = 1'b1;
          end
`endif
          default: state_d = ST_IDLE;
        endcase
      end
    end
    if (accept_c || reject_c) state_d = ST_IDLE;
  end

  // Pending load, PPS strobe and error counting; an accept coincident with pps is stale.
  always_comb begin
    ld_sec_d  = ld_sec_q;
    ld_min_d  = ld_min_q;
    ld_hour_d = ld_hour_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    pending_d = pending_q;
    write_d   = pps && pending_q;
    ok_d      = 1'b0;
    err_d     = err_q;
    if (pps && pending_q) begin
      sec_d  = ld_sec_q;
      min_d  = ld_min_q;
      hour_d = ld_hour_q;
    end
    if (pps) begin
      pending_d = 1'b0;
    end else if (accept_c) begin
      pending_d = 1'b1;
      ok_d      = 1'b1;
      ld_sec_d  = inc_ss;
      ld_min_d  = inc_mm;
      ld_hour_d = inc_hh;
    end
    if (reject_c && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      bcd_q     <= 24'd0;
`ifdef NMEA_CHECKSUM_EN
      acc_q     <= 8'd0;
      ck_hi_q   <= 4'd0;
`endif
      ld_sec_q  <= 6'd0;
      ld_min_q  <= 6'd0;
      ld_hour_q <= 6'd0;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hour_q    <= 6'd0;
      write_q   <= 1'b0;
      pending_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
`ifdef NMEA_CHECKSUM_EN
      acc_q     <= acc_d;
      ck_hi_q   <= ck_hi_d;
`endif
      ld_sec_q  <= ld_sec_d;
      ld_min_q  <= ld_min_d;
      ld_hour_q <= ld_hour_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      write_q   <= write_d;
      pending_q <= pending_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign sec_out      = sec_q;
  assign min_out      = min_q;
  assign hour_out     = hour_q;
  assign write_data   = write_q;
  assign time_pending = pending_q;
  assign sentence_ok  = ok_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_nmea_time_loader.sv
// Directed bench for nmea_time_loader: two instances (hour offset 0 and 2) share one byte stream.
module tb_nmea_time_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pps;

  logic [5:0] sec0, min0, hour0, sec2, min2, hour2;
  logic       wr0, pend0, ok0, wr2, pend2, ok2;
  logic [7:0] err0, err2;

  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  logic ok_seen;
  logic wr_seen;

  always #5 clk = ~clk;

  nmea_time_loader #(.HOUR_OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .pps(pps),
    .sec_out(sec0), .min_out(min0), .hour_out(hour0), .write_data(wr0),
    .time_pending(pend0), .sentence_ok(ok0), .err_count(err0)
  );

  nmea_time_loader #(.HOUR_OFFSET(2)) dut2 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .pps(pps),
    .sec_out(sec2), .min_out(min2), .hour_out(hour2), .write_data(wr2),
    .time_pending(pend2), .sentence_ok(ok2), .err_count(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    rx_data  = b;
    rx_valid = 1'b1;
    pps      = p;
    step();
    rx_valid = 1'b0;
    pps      = 1'b0;
    ok_seen  = ok_seen | ok0;
    wr_seen  = wr_seen | wr0;
  endtask

  function automatic logic [7:0] nmea_cs(input string s);
    logic [7:0] a = 8'd0;
    for (int i = 0; i < s.len(); i++) a = a ^ s[i];
    return a;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n, input logic lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  // Sends $body*HH\r\n; pps_end raises pps together with the byte that completes the sentence.
  task automatic send_sentence(input string body, input logic bad_cs, input logic lower,
                               input logic pps_end);
    logic [7:0] cs;
    cs = nmea_cs(body) ^ (bad_cs ? 8'h01 : 8'h00);
    ok_seen = 1'b0;
    wr_seen = 1'b0;
    send_byte(8'h24, 1'b0);
    for (int i = 0; i < body.len(); i++) send_byte(body[i], 1'b0);
`ifdef NMEA_CHECKSUM_EN
    send_byte(8'h2A, 1'b0);
    send_byte(hex_char(cs[7:4], lower), 1'b0);
    send_byte(hex_char(cs[3:0], lower), pps_end);
`else
    send_byte(8'h2A, pps_end);
    send_byte(hex_char(cs[7:4], lower), 1'b0);
    send_byte(hex_char(cs[3:0], lower), 1'b0);
`endif
    send_byte(8'h0D, 1'b0);
    send_byte(8'h0A, 1'b0);
  endtask

  task automatic chk_out(input string tag, input int h0, input int m0, input int s0,
                         input int h2, input int m2, input int s2);
    chk({tag, "_hour0"}, 32'(hour0), h0);
    chk({tag, "_min0"},  32'(min0),  m0);
    chk({tag, "_sec0"},  32'(sec0),  s0);
    chk({tag, "_hour2"}, 32'(hour2), h2);
    chk({tag, "_min2"},  32'(min2),  m2);
    chk({tag, "_sec2"},  32'(sec2),  s2);
  endtask

  task automatic chk_accepted(input string tag);
    chk({tag, "_ok"},    32'(ok_seen), 1);
    chk({tag, "_pend0"}, 32'(pend0),   1);
    chk({tag, "_pend2"}, 32'(pend2),   1);
    chk({tag, "_err0"},  32'(err0),    exp_err);
  endtask

  task automatic chk_rejected(input string tag);
    chk({tag, "_ok"},    32'(ok_seen), 0);
    chk({tag, "_pend0"}, 32'(pend0),   0);
    chk({tag, "_err0"},  32'(err0),    exp_err);
    chk({tag, "_err2"},  32'(err2),    exp_err);
  endtask

  // pps pulse, then the strobe must appear exactly one cycle later and only once.
  task automatic chk_strobe(input string tag, input int h0, input int m0, input int s0,
                            input int h2, input int m2, input int s2);
    pps = 1'b1;
    step();
    pps = 1'b0;
    chk({tag, "_wr0"}, 32'(wr0), 1);
    chk({tag, "_wr2"}, 32'(wr2), 1);
    chk_out(tag, h0, m0, s0, h2, m2, s2);
    step();
    chk({tag, "_wr0_off"}, 32'(wr0), 0);
    chk({tag, "_pend_clr"}, 32'(pend0), 0);
  endtask

  initial begin
    string body;
    string partial;
    logic [7:0] base_cs;
    logic [7:0] pad;
    rst = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; pps = 1'b0;
    ok_seen = 1'b0; wr_seen = 1'b0;
    repeat (3) step();
    chk("rst_wr",   32'(wr0),   0);
    chk("rst_pend", 32'(pend0), 0);
    chk("rst_ok",   32'(ok0),   0);
    chk("rst_err",  32'(err0),  0);
    chk_out("rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();

    // Basic RMC with fractional seconds.
    send_sentence("GPRMC,123456.00,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 1'b0, 1'b0, 1'b0);
    chk_accepted("t1");
    chk_strobe("t1", 12, 34, 57, 14, 34, 57);
    step();
    chk_out("t1_hold", 12, 34, 57, 14, 34, 57);

    // Full carry chain and hour offset wrap.
    send_sentence("GNRMC,235959,A,,", 1'b0, 1'b0, 1'b0);
    chk_accepted("t2a");
    chk_strobe("t2a", 0, 0, 0, 2, 0, 0);
    send_sentence("GPRMC,225959,A,,", 1'b0, 1'b0, 1'b0);
    chk_accepted("t2b");
    chk_strobe("t2b", 23, 0, 0, 1, 0, 0);

    // Rejected sentences.
    send_sentence("GPRMC,123456,V,,", 1'b0, 1'b0, 1'b0);
    exp_err++; chk_rejected("t3_void");
    send_sentence("GPRMC,240000,A,,", 1'b0, 1'b0, 1'b0);
    exp_err++; chk_rejected("t3_hh24");
    send_sentence("GPRMC,12a456,A,,", 1'b0, 1'b0, 1'b0);
    exp_err++; chk_rejected("t3_nondigit");
    send_sentence("GPRMC,235960,A,,", 1'b0, 1'b0, 1'b0);
    exp_err++; chk_rejected("t3_leap");
    pps = 1'b1; step(); pps = 1'b0;
    chk("t3_no_wr", 32'(wr0), 0);
    chk_out("t3_hold", 23, 0, 0, 1, 0, 0);

`ifdef NMEA_CHECKSUM_EN
    send_sentence("GPRMC,101010,A,,", 1'b1, 1'b0, 1'b0);
    exp_err++; chk_rejected("t4_badcs");
    // Pad byte chosen so the low checksum digit is a hex letter, exercising lowercase parsing.
    base_cs = nmea_cs("GPRMC,101010,A,,");
    pad = 8'h40;
    for (int p = 8'h40; p <= 8'h4F; p++) begin
      if (((base_cs ^ 8'(p)) & 8'h0F) >= 8'h0A) pad = 8'(p);
    end
    body = "GPRMC,101010,A,,Q";
    body[body.len() - 1] = pad;
    send_sentence(body, 1'b0, 1'b1, 1'b0);
    chk_accepted("t4_lower");
    chk_strobe("t4_lower", 10, 10, 11, 12, 10, 11);
`else
    base_cs = 8'd0;
    pad = 8'd0;
    body = "";
`endif

    // Non-RMC is silently ignored.
    send_sentence("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,", 1'b0, 1'b0, 1'b0);
    chk_rejected("t5_gga");

    // '$' mid-sentence restarts parsing.
    partial = "$GPRMC,1234";
    for (int i = 0; i < partial.len(); i++) send_byte(partial[i], 1'b0);
    send_sentence("GPRMC,010203,A,,", 1'b0, 1'b0, 1'b0);
    chk_accepted("t5_restart");
    chk_strobe("t5_restart", 1, 2, 4, 3, 2, 4);

    // Accept coincident with pps: existing pending is consumed, the new one discarded.
    send_sentence("GPRMC,050505,A,,", 1'b0, 1'b0, 1'b0);
    chk_accepted("t6_first");
    send_sentence("GPRMC,070707,A,,", 1'b0, 1'b0, 1'b1);
    chk("t6_wr_seen", 32'(wr_seen), 1);
    chk("t6_no_ok",   32'(ok_seen), 0);
    chk("t6_pend",    32'(pend0),   0);
    chk("t6_err",     32'(err0),    exp_err);
    chk_out("t6_load", 5, 5, 6, 7, 5, 6);
    pps = 1'b1; step(); pps = 1'b0;
    chk("t6_stale_wr", 32'(wr0), 0);

    // Reset mid-sentence with a load pending.
    send_sentence("GPRMC,080808,A,,", 1'b0, 1'b0, 1'b0);
    chk_accepted("t7_pre");
    partial = "$GPRMC,1122";
    for (int i = 0; i < partial.len(); i++) send_byte(partial[i], 1'b0);
    rst = 1'b0;
    step();
    exp_err = 0;
    chk("t7_rst_pend", 32'(pend0), 0);
    chk("t7_rst_err",  32'(err0),  0);
    chk("t7_rst_wr",   32'(wr0),   0);
    chk_out("t7_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    send_sentence("GPRMC,112233,A,,", 1'b0, 1'b0, 1'b0);
    chk_accepted("t7_post");
    chk_strobe("t7_post", 11, 22, 34, 13, 22, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
